axis_pkt_buffer: RTL and testbench
==================================

// Module: axis_pkt_buffer
// PURPOSE
//   Store-and-forward AXI-Stream packet buffer, successor of the single-packet stream-to-FIFO capture block.
//   Accepts one packet (up to DEPTH beats) on a full tvalid/tready/tlast slave port.
//   Replays the packet on an AXI-Stream master port with backpressure and reports its length.
//   Sits between the DMA stream source and downstream FIFO/processing stages.
// PARAMETERS
//   DATA_WIDTH  32  tdata width in bits, >=1
//   DEPTH       16  max beats per packet, >=2; ADDR_W = $clog2(DEPTH) (localparam)
// PORTS
//   clk            in   1              single clock, rising edge
//   rst_n          in   1              asynchronous, active-low reset
//   s_axis_tdata   in   DATA_WIDTH     input beat data
//   s_axis_tvalid  in   1              input beat valid
//   s_axis_tlast   in   1              final beat of input packet
//   s_axis_tready  out  1              buffer accepts beat
//   m_axis_tdata   out  DATA_WIDTH     output beat data
//   m_axis_tvalid  out  1              output beat valid
//   m_axis_tlast   out  1              final beat of output packet
//   m_axis_tready  in   1              downstream accepts beat
//   pkt_len        out  ADDR_W+1       beats in packet being drained, 1..DEPTH
//   busy           out  1              high in any state other than IDLE
//   overflow       out  1              1-cycle pulse when a packet exceeds DEPTH
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, wr/rd ptr=0, count=0.
//     All outputs 0 except s_axis_tready=1. Memory contents not cleared.
//     A packet in flight at reset is lost.
//   - Beat transfer = tvalid & tready on the same rising edge. Every tdata value, including 0, is data.
//   - IDLE: s_axis_tready=1. First beat written to mem[0].
//     tlast=1 -> DRAIN with len 1; else -> FILL.
//   - FILL: s_axis_tready=1. Each beat goes to mem[wr_ptr]; wr_ptr++.
//     - tlast on beat k (k<=DEPTH): -> DRAIN, pkt_len=k.
//     - DEPTH-th beat without tlast: -> DISCARD, overflow pulses the next cycle.
//   - DISCARD: s_axis_tready=1. Beats are dropped until a beat with tlast is accepted.
//     Exit target depends on OVERFLOW_DROP_EN (see CONFIGURATION).
//   - DRAIN: s_axis_tready=0 (no simultaneous fill and drain).
//     - m_axis_tvalid=1 from the cycle after the input tlast beat (1-cycle latency).
//     - m_axis_tdata=mem[rd_ptr]; m_axis_tlast=(rd_ptr==pkt_len-1).
//     - On each transfer rd_ptr++. tdata/tlast are held stable while m_axis_tready=0.
//     - Transfer with tlast -> IDLE. tvalid=0 and s_axis_tready=1 the next cycle.
//   - pkt_len is valid throughout DRAIN and holds its value in IDLE until the next packet completes.
//   - Pointer width ADDR_W. rd_ptr never wraps within a packet; both pointers reset to 0 on entry to IDLE.
//   - Exact fit (DEPTH beats, tlast on the last one): no overflow, normal DRAIN.
//   - s_axis_tvalid low mid-packet: FILL waits indefinitely, no timeout.
// CONFIGURATION
//   OVERFLOW_DROP_EN
//     - Undefined (truncate): DISCARD -> DRAIN with pkt_len=DEPTH.
//       The first DEPTH beats are replayed, with m_axis_tlast forced on beat DEPTH.
//     - Defined (drop): DISCARD -> IDLE. Nothing is output for the oversized packet.
//   overflow pulses in both modes.
// TESTING
//   1. DEPTH=16, 4-beat packet 0x11,0x22,0x33,0x44, m_axis_tready=1
//      -> 4 output beats, tvalid 1 cycle after input tlast, tlast on 0x44, pkt_len=4.
//   2. Single beat 0x0 with tlast in IDLE
//      -> one output beat 0x0 with tlast; pkt_len=1; zero data not filtered.
//   3. 16-beat packet, tlast on beat 16
//      -> no overflow pulse; 16 beats out, tlast on 16th.
//   4. 20-beat packet 1..20
//      -> overflow pulse one cycle after beat 16; beats 17..20 accepted and dropped.
//      -> Without macro: output 1..16, tlast on 16. With OVERFLOW_DROP_EN: no output, busy clears after beat 20.
//   5. m_axis_tready toggled 1,0,0,1 during DRAIN of 3-beat packet
//      -> data held stable while stalled; s_axis_tready=0 throughout DRAIN; 3 transfers total.
//   6. rst_n asserted mid-FILL and mid-DRAIN
//      -> immediate IDLE outputs (m_axis_tvalid=0, busy=0, s_axis_tready=1); next packet processed correctly.

Source files
------------

// File: rtl/axis_pkt_buffer.sv
// Store-and-forward AXI-Stream packet buffer: capture one packet, then replay it.
// Define OVERFLOW_DROP_EN to drop oversized packets instead of truncating them.
module axis_pkt_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [$clog2(DEPTH):0]        pkt_len,
  output logic                          busy,
  output logic                          overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DISCARD,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W:0]       len_q;
  logic                  ovf_q;
  logic                  in_beat;
  logic                  out_beat;
  logic                  at_end;
  logic                  rd_last;

  assign in_beat  = s_axis_tvalid & s_axis_tready;
  assign out_beat = m_axis_tvalid & m_axis_tready;
  assign at_end   = (wr_ptr == ADDR_W'(DEPTH-1));
  assign rd_last  = ({1'b0, rd_ptr} == (len_q - ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_beat) begin
          state_nx = s_axis_tlast ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (in_beat) begin
          if (s_axis_tlast) begin
            state_nx = DRAIN;
          end else if (at_end) begin
            state_nx = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (in_beat && s_axis_tlast) begin
`ifdef OVERFLOW_DROP_EN
          state_nx = IDLE;
`else
          state_nx = DRAIN;
`endif
        end
      end
      DRAIN: begin
        if (out_beat && rd_last) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        s_axis_tready = 1'b1;
        busy          = 1'b0;
      end
      FILL, DISCARD: begin
        s_axis_tready = 1'b1;
      end
      DRAIN: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = rd_last;
        m_axis_tdata  = mem[rd_ptr];
      end
      default: busy = 1'b0;
    endcase
  end

  // Pointers return to zero whenever the block goes back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      len_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= (state == FILL) & in_beat
             & ~s_axis_tlast & at_end;
      unique case (state)
        IDLE, FILL: begin
          if (in_beat) begin
            wr_ptr <= at_end ? '0
                    : wr_ptr + ADDR_W'(1);
            if (s_axis_tlast) begin
              len_q <= {1'b0, wr_ptr} + ONE;
            end
          end
        end
        DISCARD: begin
          if (in_beat && s_axis_tlast) begin
            wr_ptr <= '0;
`ifndef OVERFLOW_DROP_EN
            len_q  <= (ADDR_W+1)'(DEPTH);
`endif
          end
        end
        DRAIN: begin
          if (out_beat) begin
            if (rd_last) begin
              rd_ptr <= '0;
              wr_ptr <= '0;
            end else begin
              rd_ptr <= rd_ptr + ADDR_W'(1);
            end
          end
        end
        default: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
      endcase
    end
  end

  // Storage is not reset; only beats of the current packet are ever read.
  always_ff @(posedge clk) begin
    if (in_beat && (state != DISCARD)) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  assign pkt_len  = len_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_axis_pkt_buffer.sv
// Randomized bench for axis_pkt_buffer with a packet-level queue model.
// Honours OVERFLOW_DROP_EN when defined for the build.
module tb_axis_pkt_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
`ifdef OVERFLOW_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [AW:0]   pkt_len;
  logic          busy;
  logic          overflow;

  axis_pkt_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .pkt_len(pkt_len),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Packet-level model: beats collected so far, and beats owed downstream.
  logic [DW-1:0] pkt[$];
  logic [DW-1:0] outq[$];
  int            n_in = 0;
  int            exp_len = 0;
  bit            exp_ovf = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      pkt.delete();
      outq.delete();
      n_in = 0;
      exp_len = 0;
      exp_ovf = 1'b0;
    end else begin
      bit rdy;
      rdy = (outq.size() == 0);
      exp_ovf = 1'b0;
      if (m_tready && outq.size() > 0) void'(outq.pop_front());
      if (s_tvalid && rdy) begin
        n_in++;
        if (pkt.size() < DEPTH) pkt.push_back(s_tdata);
        if (n_in == DEPTH && !s_tlast) exp_ovf = 1'b1;
        if (s_tlast) begin
          if (n_in <= DEPTH || !DROP) begin
            outq = pkt;
            exp_len = pkt.size();
          end
          pkt.delete();
          n_in = 0;
        end
      end
    end
  end

  // Output log used by the directed checks.
  logic [DW-1:0] seen_d[$];
  bit            seen_l[$];
  int            ovf_cnt = 0;
  int            first_out_cyc = -1;
  int            last_in_cyc = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_tready", 32'(s_tready), 32'd1);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_pkt_len", 32'(pkt_len), 32'd0);
    end else begin
      chk("s_tready", 32'(s_tready), 32'(outq.size() == 0));
      chk("m_tvalid", 32'(m_tvalid), 32'(outq.size() > 0));
      chk("busy", 32'(busy),
          32'(outq.size() > 0 || n_in > 0));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("pkt_len", 32'(pkt_len), 32'(exp_len));
      if (outq.size() > 0) begin
        chk("m_tdata", m_tdata, outq[0]);
        chk("m_tlast", 32'(m_tlast), 32'(outq.size() == 1));
      end
      if (overflow) ovf_cnt++;
      if (m_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
      if (m_tvalid && m_tready) begin
        seen_d.push_back(m_tdata);
        seen_l.push_back(m_tlast);
      end
    end
  end

  // Downstream ready: 0 always on, 1 random, 2 scripted, 3 always off.
  int rdy_mode = 0;
  bit rdy_pat[$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = 1'($urandom_range(0, 1));
        2: begin
          if (m_tvalid && rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
          else m_tready = 1'b1;
        end
        default: m_tready = 1'b0;
      endcase
    end
  end

  logic [DW-1:0] tx[$];

  task automatic clear_log();
    seen_d.delete();
    seen_l.delete();
    ovf_cnt = 0;
    first_out_cyc = -1;
    last_in_cyc = -1;
  endtask

  task automatic send(input bit with_last, input int gap);
    for (int i = 0; i < tx.size(); i++) begin
      bit hs;
      int budget;
      hs = 1'b0;
      budget = 1000;
      s_tdata = tx[i];
      s_tlast = with_last && (i == tx.size() - 1);
      while (!hs && budget > 0) begin
        s_tvalid = ($urandom_range(0, 99) >= gap);
        @(negedge clk);
        hs = s_tvalid && s_tready;
        if (hs && s_tlast) last_in_cyc = cyc;
        @(posedge clk);
        #1;
        budget--;
      end
      if (!hs) begin
        chk("send_timeout", 32'(hs), 32'd1);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 1000;
    while (budget > 0) begin
      @(negedge clk);
      if (!busy && !m_tvalid) break;
      budget--;
    end
    if (budget == 0) chk("idle_timeout", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_s_tready", 32'(s_tready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 4-beat packet at full downstream rate
    rdy_mode = 0;
    clear_log();
    tx = '{32'h11, 32'h22, 32'h33, 32'h44};
    send(1'b1, 0);
    wait_idle();
    chk("t1_count", 32'(seen_d.size()), 32'd4);
    if (seen_d.size() == 4) begin
      chk("t1_d0", seen_d[0], 32'h11);
      chk("t1_d3", seen_d[3], 32'h44);
      chk("t1_last0", 32'(seen_l[0]), 32'd0);
      chk("t1_last3", 32'(seen_l[3]), 32'd1);
    end
    chk("t1_latency", 32'(first_out_cyc - last_in_cyc), 32'd1);
    chk("t1_len_hold", 32'(pkt_len), 32'd4);

    // single zero beat
    clear_log();
    tx = '{32'h0};
    send(1'b1, 0);
    wait_idle();
    chk("t2_count", 32'(seen_d.size()), 32'd1);
    if (seen_d.size() == 1) begin
      chk("t2_data", seen_d[0], 32'h0);
      chk("t2_last", 32'(seen_l[0]), 32'd1);
    end
    chk("t2_len", 32'(pkt_len), 32'd1);

    // exact fit
    clear_log();
    tx.delete();
    for (int i = 1; i <= 16; i++) tx.push_back(32'(i));
    send(1'b1, 0);
    wait_idle();
    chk("t3_ovf", 32'(ovf_cnt), 32'd0);
    chk("t3_count", 32'(seen_d.size()), 32'd16);
    if (seen_d.size() == 16) begin
      chk("t3_d15", seen_d[15], 32'd16);
      chk("t3_last15", 32'(seen_l[15]), 32'd1);
    end

    // oversized packet
    clear_log();
    tx.delete();
    for (int i = 1; i <= 20; i++) tx.push_back(32'(i));
    send(1'b1, 0);
    wait_idle();
    chk("t4_ovf", 32'(ovf_cnt), 32'd1);
    chk("t4_count", 32'(seen_d.size()), DROP ? 32'd0 : 32'd16);
    if (!DROP && seen_d.size() == 16) begin
      chk("t4_d15", seen_d[15], 32'd16);
      chk("t4_last15", 32'(seen_l[15]), 32'd1);
      chk("t4_len", 32'(pkt_len), 32'd16);
    end

    // stalled drain
    clear_log();
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rdy_mode = 2;
    tx = '{32'hA1, 32'hB2, 32'hC3};
    send(1'b1, 0);
    wait_idle();
    chk("t5_count", 32'(seen_d.size()), 32'd3);
    if (seen_d.size() == 3) chk("t5_d1", seen_d[1], 32'hB2);

    // reset mid-FILL, then a clean packet
    rdy_mode = 0;
    tx = '{32'h5, 32'h6, 32'h7};
    send(1'b0, 0);
    do_reset();
    clear_log();
    tx = '{32'h99, 32'h98};
    send(1'b1, 0);
    wait_idle();
    chk("t6a_count", 32'(seen_d.size()), 32'd2);

    // reset mid-DRAIN
    rdy_mode = 3;
    tx = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    send(1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    rdy_mode = 0;
    clear_log();
    tx = '{32'h77};
    send(1'b1, 0);
    wait_idle();
    chk("t6b_count", 32'(seen_d.size()), 32'd1);

    // random traffic
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, DEPTH + 6);
      tx.delete();
      for (int i = 0; i < len; i++) tx.push_back($urandom());
      send(1'b1, $urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
